// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - memory-mapped bus bundle for the UART transmitter
interface mmio_uart_tx_if;
    logic [31:0] bus_address;
    logic [31:0] bus_wr_data;
    logic        bus_wr_en;
    logic [31:0] bus_rd_data;

    modport master (
        output bus_address,
        output bus_wr_data,
        output bus_wr_en,
        input  bus_rd_data
    );

    modport slave (
        input  bus_address,
        input  bus_wr_data,
        input  bus_wr_en,
        output bus_rd_data
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with 4-entry FIFO
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [31:0] DATA_ADDR    = 32'd260,
    parameter logic [31:0] STAT_ADDR    = 32'd264
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          tx_busy
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_baud;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;

    logic [7:0]  r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic        r_overflow;

    logic        w_full;
    logic        w_empty;
    logic        w_wr_data;
    logic        w_wr_stat;
    logic        w_push;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic        w_baud_end;
    logic        w_pop;
    logic        w_tx;
    logic        w_unused;

    assign w_full     = (r_count == 3'd4);
    assign w_empty    = (r_count == 3'd0);
    assign w_wr_data  = bus.bus_wr_en && (bus.bus_address == DATA_ADDR);
    assign w_wr_stat  = bus.bus_wr_en && (bus.bus_address == STAT_ADDR);
    // Fullness is judged on the count before this edge, so a push into a
    // full FIFO is dropped even when the FSM pops in the same cycle.
    assign w_push     = w_wr_data && !w_full;
    assign w_ovf_set  = w_wr_data && w_full;
    assign w_ovf_clr  = w_wr_stat && bus.bus_wr_data[3];
    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_unused   = &{1'b0, bus.bus_wr_data[31:8]};

    assign tx      = r_tx;
    assign tx_busy = (r_state != S_IDLE) || !w_empty;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state decode; each non-idle state lasts one bit time
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_next = S_START;
            S_START: if (w_baud_end) w_next = S_DATA;
            S_DATA:  if (w_baud_end && (r_bit_idx == 3'd7)) w_next = S_STOP;
            S_STOP:  if (w_baud_end) w_next = w_empty ? S_IDLE : S_START;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs: line level for the current bit and FIFO pop request
    always_comb begin
        w_tx  = 1'b1;
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = !w_empty;
            S_START: w_tx  = 1'b0;
            S_DATA:  w_tx  = r_shift[r_bit_idx];
            S_STOP:  w_pop = w_baud_end && !w_empty;
            default: w_tx  = 1'b1;
        endcase
    end

    // Baud counter, bit index, shift register and registered serial line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx      <= 1'b1;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_tx <= w_tx;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end
            // Counter restarts at every bit boundary, which includes every state entry
            if ((r_state == S_IDLE) || w_baud_end) begin
                r_baud <= 16'd0;
            end else begin
                r_baud <= r_baud + 16'd1;
            end
            // Index wraps 7->0 as DATA exits, so it is zero on the next entry
            if (r_state == S_DATA) begin
                if (w_baud_end) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_bit_idx <= 3'd0;
            end
        end
    end

    // FIFO storage; contents need no reset since the count gates visibility
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= bus.bus_wr_data[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Combinational register read mux; reading never pops
    always_comb begin
        bus.bus_rd_data = 32'd0;
        if (bus.bus_address == STAT_ADDR) begin
            bus.bus_rd_data = {25'd0, r_count, r_overflow, tx_busy, w_empty, w_full};
        end else if (bus.bus_address == DATA_ADDR) begin
            if (!w_empty) begin
                bus.bus_rd_data = {24'd0, r_mem[r_rd_ptr]};
            end
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
    localparam int C     = 4;
    localparam int FRAME = 10 * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic tx_busy;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] seq_b [5];
    logic [7:0] seq_c [6];
    logic [7:0] seq_d [3];

    mmio_uart_tx_if bus_if ();

    mmio_uart_tx #(
        .CLKS_PER_BIT(C),
        .DATA_ADDR   (32'd260),
        .STAT_ADDR   (32'd264)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if.slave),
        .tx     (tx),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Line level for bit slot i of an 8N1 frame carrying b
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        else if (i <= 8) return b[i-1];
        else return 1'b1;
    endfunction

    task automatic drive_wr(input logic [31:0] addr, input logic [31:0] data);
        bus_if.bus_address = addr;
        bus_if.bus_wr_data = data;
        bus_if.bus_wr_en   = 1'b1;
    endtask

    task automatic drive_idle();
        bus_if.bus_wr_en   = 1'b0;
        bus_if.bus_wr_data = 32'd0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus_if.bus_wr_en   = 1'b0;
        bus_if.bus_address = addr;
        #1;
        chk(tag, bus_if.bus_rd_data, exp);
    endtask

    initial begin
        seq_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        seq_c = '{8'h01, 8'h3C, 8'h03, 8'h04, 8'h05, 8'h06};
        seq_d = '{8'hC3, 8'h5A, 8'h0F};

        // Reset, with a write attempted under reset that must be ignored
        bus_if.bus_address = 32'd0;
        bus_if.bus_wr_data = 32'd0;
        bus_if.bus_wr_en   = 1'b0;
        rst = 1'b1;
        drive_wr(32'd260, 32'h000000AA);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive_idle();
        rd_chk("rst_stat", 32'd264, 32'h00000002);
        rd_chk("rst_data", 32'd260, 32'h00000000);
        rd_chk("bad_addr", 32'd256, 32'h00000000);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);

        // Single frame 0xA5 (upper data bits ignored), latency and busy fall
        for (int k = 0; k <= FRAME + 1; k++) begin
            if (k == 0) drive_wr(32'd260, 32'hFFFFFFA5);
            else drive_idle();
            @(negedge clk);
            if (k >= 2) chk("a_tx", {31'd0, tx}, {31'd0, frame_bit(8'hA5, (k - 2) / C)});
            else chk("a_tx_lat", {31'd0, tx}, 32'd1);
            if (k == 1) rd_chk("a_pop_stat", 32'd264, 32'h00000006);
            if (k == FRAME) chk("a_busy", {31'd0, tx_busy}, 32'd1);
            if (k == FRAME + 1) chk("a_busy_fall", {31'd0, tx_busy}, 32'd0);
        end

        // Five consecutive writes: first popped, four queued, contiguous frames
        for (int k = 0; k <= 5 * FRAME + 1; k++) begin
            if (k < 5) drive_wr(32'd260, {24'd0, seq_b[k]});
            else drive_idle();
            @(negedge clk);
            if (k >= 2) chk("b_tx", {31'd0, tx},
                            {31'd0, frame_bit(seq_b[(k - 2) / FRAME], ((k - 2) % FRAME) / C)});
            else chk("b_tx_lat", {31'd0, tx}, 32'd1);
            if (k == 5) rd_chk("b_stat_full", 32'd264, 32'h00000045);
            if (k == 5 * FRAME) chk("b_busy", {31'd0, tx_busy}, 32'd1);
            if (k == 5 * FRAME + 1) chk("b_busy_fall", {31'd0, tx_busy}, 32'd0);
        end

        // Overflow, non-popping head read, clear, push-while-full with pop
        for (int k = 0; k <= 45; k++) begin
            if (k < 6) drive_wr(32'd260, {24'd0, seq_c[k]});
            else if (k == 10) drive_wr(32'd264, 32'h00000008);
            else if (k == 41) drive_wr(32'd260, 32'h00000099);
            else drive_idle();
            @(negedge clk);
            if (k >= 2) begin
                if ((k - 2) < FRAME) chk("c_tx", {31'd0, tx}, {31'd0, frame_bit(8'h01, (k - 2) / C)});
                else chk("c_tx2", {31'd0, tx}, {31'd0, frame_bit(8'h3C, (k - 2 - FRAME) / C)});
            end
            if (k == 5) rd_chk("c_ovf_stat", 32'd264, 32'h0000004D);
            if (k == 6) begin
                rd_chk("c_head", 32'd260, 32'h0000003C);
                rd_chk("c_no_pop", 32'd264, 32'h0000004D);
            end
            if (k == 10) rd_chk("c_ovf_clr", 32'd264, 32'h00000045);
            if (k == 41) begin
                rd_chk("c_full_pop_stat", 32'd264, 32'h0000003C);
                rd_chk("c_full_pop_head", 32'd260, 32'h00000003);
            end
        end

        // Clean reset, then abort a frame during data bit 3 with bytes queued
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        rd_chk("d_rst_stat", 32'd264, 32'h00000002);
        for (int k = 0; k <= 70; k++) begin
            rst = 1'b0;
            if (k < 3) drive_wr(32'd260, {24'd0, seq_d[k]});
            else if (k == 18) begin
                rst = 1'b1;
                drive_wr(32'd260, 32'h00000077);
            end else drive_idle();
            @(negedge clk);
            if (k == 3) rd_chk("d_queued", 32'd264, 32'h00000024);
            if (k >= 2 && k < 18) chk("d_tx", {31'd0, tx}, {31'd0, frame_bit(8'hC3, (k - 2) / C)});
            if (k >= 18) begin
                chk("d_abort_tx", {31'd0, tx}, 32'd1);
                chk("d_abort_busy", {31'd0, tx_busy}, 32'd0);
            end
            if (k == 18) begin
                rst = 1'b0;
                rd_chk("d_abort_stat", 32'd264, 32'h00000002);
            end
            if (k == 70) rd_chk("d_end_stat", 32'd264, 32'h00000002);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
